// File: rtl/reg_writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regwb_pkg
// Brief    : Shared widths, the zero-register constant and the queue entry type
//            for the register-file writeback unit.
// Revision : 1.0
// ============================================================================
package regwb_pkg;

    localparam int ADDR_W_DFLT = 5;
    localparam int DATA_W_DFLT = 32;

    localparam logic [ADDR_W_DFLT-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                   live;
        logic [ADDR_W_DFLT-1:0] adr;
        logic [DATA_W_DFLT-1:0] data;
    } regwb_entry_t;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit_if
// Brief    : Primary/secondary request, decode check and register-file port
//            bundle. master = pipeline side, slave = writeback unit.
// Revision : 1.0
// ============================================================================
interface reg_writeback_unit_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic                       pri_we;
    logic [ADDR_W-1:0]          pri_adr;
    logic [DATA_W-1:0]          pri_data;
    logic                       sec_valid;
    logic                       sec_ready;
    logic [ADDR_W-1:0]          sec_adr;
    logic [DATA_W-1:0]          sec_data;
    logic [ADDR_W-1:0]          chk_adr1;
    logic [ADDR_W-1:0]          chk_adr2;
    logic                       chk_hit1;
    logic                       chk_hit2;
    logic                       RegWrite;
    logic [ADDR_W-1:0]          writeadr;
    logic [DATA_W-1:0]          WriteData;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output pri_we, pri_adr, pri_data,
        output sec_valid, sec_adr, sec_data,
        output chk_adr1, chk_adr2,
        input  sec_ready, chk_hit1, chk_hit2,
        input  RegWrite, writeadr, WriteData, count
    );

    modport slave (
        input  pri_we, pri_adr, pri_data,
        input  sec_valid, sec_adr, sec_data,
        input  chk_adr1, chk_adr2,
        output sec_ready, chk_hit1, chk_hit2,
        output RegWrite, writeadr, WriteData, count
    );
endinterface
`default_nettype wire

// File: rtl/regwb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regwb_fifo
// Brief    : In-order secondary write queue with per-entry live bit, WAW kill
//            compare and decode pending-write compare.
// Revision : 1.0
// ============================================================================
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    push,
    input  wire regwb_entry_t            push_entry,
    input  wire logic                    pop,
    input  wire logic                    kill_en,
    input  wire logic [ADDR_W_DFLT-1:0]  kill_adr,
    input  wire logic [ADDR_W_DFLT-1:0]  chk_adr1,
    input  wire logic [ADDR_W_DFLT-1:0]  chk_adr2,
    output regwb_entry_t                 head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         hit1,
    output logic                         hit2
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    regwb_entry_t   r_mem [DEPTH];
    logic [PW-1:0]  r_wr;
    logic [PW-1:0]  r_rd;
    logic           w_push_live;
    logic           w_hit1;
    logic           w_hit2;

    assign count = r_wr - r_rd;
    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[IW-1:0] == r_rd[IW-1:0]) && (r_wr[IW] != r_rd[IW]);
    assign head  = r_mem[r_rd[IW-1:0]];

    // A push coinciding with a primary to the same register is already stale.
    assign w_push_live = push_entry.live && !(kill_en && (push_entry.adr == kill_adr));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && r_mem[i].live && (r_mem[i].adr == kill_adr)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            // Popped slots drop their live bit so only occupied slots can hit.
            if (pop) begin
                r_mem[r_rd[IW-1:0]].live <= 1'b0;
                r_rd                     <= r_rd + PW'(1);
            end
            if (push) begin
                r_mem[r_wr[IW-1:0]].live <= w_push_live;
                r_mem[r_wr[IW-1:0]].adr  <= push_entry.adr;
                r_mem[r_wr[IW-1:0]].data <= push_entry.data;
                r_wr                     <= r_wr + PW'(1);
            end
        end
    end

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live && (r_mem[i].adr == chk_adr1)) w_hit1 = 1'b1;
            if (r_mem[i].live && (r_mem[i].adr == chk_adr2)) w_hit2 = 1'b1;
        end
    end

    assign hit1 = w_hit1 && (chk_adr1 != REG_ZERO);
    assign hit2 = w_hit2 && (chk_adr2 != REG_ZERO);

endmodule
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_unit
// Brief    : Register-file write port arbiter: fixed-priority WB stage over a
//            queued long-latency source, registered port outputs.
//            Optional WAW kill of queued writes: define REGWB_WAW_KILL_EN.
// Revision : 1.0
// ============================================================================
module reg_writeback_unit
    import regwb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  wire logic            clk,
    input  wire logic            reset,
    reg_writeback_unit_if.slave  bus
);
    logic                   w_pri_acc;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_kill_en;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_ready;
    regwb_entry_t           w_push_entry;
    regwb_entry_t           w_head;
    logic [$clog2(DEPTH):0] w_count;

    logic                   r_regwrite;
    logic [ADDR_W-1:0]      r_writeadr;
    logic [DATA_W-1:0]      r_writedata;

    assign w_pri_acc = bus.pri_we && (bus.pri_adr != REG_ZERO);
    assign w_ready   = reset && !w_full;
    // Writes to the zero register still complete the handshake, but are dropped.
    assign w_push    = bus.sec_valid && w_ready && (bus.sec_adr != REG_ZERO);
    assign w_pop     = !w_pri_acc && !w_empty;

`ifdef REGWB_WAW_KILL_EN
    assign w_kill_en = w_pri_acc;
`else
    assign w_kill_en = 1'b0;
`endif

    assign w_push_entry.live = 1'b1;
    assign w_push_entry.adr  = bus.sec_adr;
    assign w_push_entry.data = bus.sec_data;

    regwb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .kill_en    (w_kill_en),
        .kill_adr   (bus.pri_adr),
        .chk_adr1   (bus.chk_adr1),
        .chk_adr2   (bus.chk_adr2),
        .head       (w_head),
        .empty      (w_empty),
        .full       (w_full),
        .count      (w_count),
        .hit1       (bus.chk_hit1),
        .hit2       (bus.chk_hit2)
    );

    // A killed head still pops, leaving a one-cycle bubble on the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regwrite  <= 1'b0;
            r_writeadr  <= '0;
            r_writedata <= '0;
        end else if (w_pri_acc) begin
            r_regwrite  <= 1'b1;
            r_writeadr  <= bus.pri_adr;
            r_writedata <= bus.pri_data;
        end else if (w_pop) begin
            r_regwrite <= w_head.live;
            if (w_head.live) begin
                r_writeadr  <= w_head.adr;
                r_writedata <= w_head.data;
            end
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign bus.sec_ready = w_ready;
    assign bus.count     = w_count;
    assign bus.RegWrite  = r_regwrite;
    assign bus.writeadr  = r_writeadr;
    assign bus.WriteData = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback_unit
// Brief    : Directed + random bench for reg_writeback_unit against a queue
//            based reference model. Honours REGWB_WAW_KILL_EN.
// Revision : 1.0
// ============================================================================
module tb_reg_writeback_unit;
    localparam int DEPTH = 4;
`ifdef REGWB_WAW_KILL_EN
    localparam bit KILL = 1'b1;
`else
    localparam bit KILL = 1'b0;
`endif

    typedef struct {
        bit          live;
        logic [4:0]  adr;
        logic [31:0] data;
    } m_ent_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    m_ent_t      q[$];
    logic        e_we;
    logic [4:0]  e_adr;
    logic [31:0] e_dat;
    logic [31:0] obs_rf [32];

    reg_writeback_unit_if #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) bus ();

    reg_writeback_unit #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational flags, step the model,
    // then check the registered port at the following negedge.
    task automatic cyc(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                       input logic [4:0] c1, input logic [4:0] c2);
        bit     acc_p, acc_s, rdy, h1, h2;
        m_ent_t h;
        m_ent_t n;
        bus.pri_we    = pwe;
        bus.pri_adr   = pa;
        bus.pri_data  = pd;
        bus.sec_valid = sv;
        bus.sec_adr   = sa;
        bus.sec_data  = sd;
        bus.chk_adr1  = c1;
        bus.chk_adr2  = c2;
        #1;
        rdy = (q.size() < DEPTH);
        h1  = 1'b0;
        h2  = 1'b0;
        foreach (q[i]) begin
            if (q[i].live && q[i].adr == c1 && c1 != 5'd0) h1 = 1'b1;
            if (q[i].live && q[i].adr == c2 && c2 != 5'd0) h2 = 1'b1;
        end
        chk("sec_ready", 64'(bus.sec_ready), 64'(rdy));
        chk("count",     64'(bus.count),     64'(q.size()));
        chk("chk_hit1",  64'(bus.chk_hit1),  64'(h1));
        chk("chk_hit2",  64'(bus.chk_hit2),  64'(h2));
        acc_p = pwe && (pa != 5'd0);
        acc_s = sv && rdy && (sa != 5'd0);
        if (acc_p) begin
            e_we  = 1'b1;
            e_adr = pa;
            e_dat = pd;
            if (KILL) foreach (q[i]) if (q[i].adr == pa) q[i].live = 1'b0;
        end else if (q.size() > 0) begin
            h    = q.pop_front();
            e_we = h.live;
            if (h.live) begin
                e_adr = h.adr;
                e_dat = h.data;
            end
        end else begin
            e_we = 1'b0;
        end
        if (acc_s) begin
            n.live = !(KILL && acc_p && sa == pa);
            n.adr  = sa;
            n.data = sd;
            q.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
        chk("RegWrite",  64'(bus.RegWrite),  64'(e_we));
        chk("writeadr",  64'(bus.writeadr),  64'(e_adr));
        chk("WriteData", 64'(bus.WriteData), 64'(e_dat));
        if (bus.RegWrite === 1'b1) obs_rf[bus.writeadr] = bus.WriteData;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        e_we  = 1'b0;
        e_adr = '0;
        e_dat = '0;
        foreach (obs_rf[i]) obs_rf[i] = '0;
        reset         = 1'b0;
        bus.pri_we    = 1'b0;
        bus.pri_adr   = '0;
        bus.pri_data  = '0;
        bus.sec_valid = 1'b0;
        bus.sec_adr   = '0;
        bus.sec_data  = '0;
        bus.chk_adr1  = '0;
        bus.chk_adr2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_RegWrite",  64'(bus.RegWrite),  64'd0);
        chk("rst_writeadr",  64'(bus.writeadr),  64'd0);
        chk("rst_WriteData", 64'(bus.WriteData), 64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_sec_ready", 64'(bus.sec_ready), 64'd0);
        reset = 1'b1;

        // Primary write, then a primary to r0 which must be dropped.
        cyc(1, 5, 32'hA5A5_A5A5, 0, 0, 0, 0, 0);
        chk("pri5_we", 64'(bus.RegWrite), 64'd1);
        chk("pri5_data", 64'(bus.WriteData), 64'hA5A5_A5A5);
        cyc(1, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
        chk("pri0_we", 64'(bus.RegWrite), 64'd0);

        // Fill the queue under primary pressure; the fifth request sees full.
        for (int i = 0; i < 5; i++)
            cyc(1, 5'(1 + i), 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i), 5'd10, 5'd13);
        chk("full_count", 64'(bus.count), 64'd4);
        idle(6);

        // Two queued writes held back by continuous primary traffic.
        cyc(1, 2, 32'h22, 1, 17, 32'h1717, 17, 18);
        cyc(1, 3, 32'h33, 1, 18, 32'h1818, 17, 18);
        for (int i = 0; i < 3; i++) cyc(1, 4, 32'(i), 0, 0, 0, 17, 18);
        chk("held_count", 64'(bus.count), 64'd2);
        idle(3);

        // WAW: queued secondary to r9 overtaken by a newer primary to r9.
        cyc(1, 3, 32'h3, 1, 9, 32'h99, 9, 0);
        cyc(1, 9, 32'h1, 0, 0, 0, 9, 0);
        idle(3);
        chk("waw_r9", 64'(obs_rf[9]), KILL ? 64'h1 : 64'h99);

        // Interleaved push/pop across pointer wrap.
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, 1, 5'(20 + (i % 8)), 32'hC0DE_0000 + 32'(i), 5'(20 + (i % 8)), 0);
        idle(2);

        // Random traffic over a small register set to provoke hits and kills.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(6);

        // Asynchronous reset with three queued writes.
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 32'(i), 1, 5'(25 + i), 32'hDEAD_0000 + 32'(i), 25, 0);
        chk("pre_rst_count", 64'(bus.count), 64'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_count",    64'(bus.count),    64'd0);
        chk("arst_RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("arst_ready",    64'(bus.sec_ready), 64'd0);
        chk("arst_hit1",     64'(bus.chk_hit1), 64'd0);
        q.delete();
        e_we  = 1'b0;
        e_adr = '0;
        e_dat = '0;
        @(negedge clk);
        reset = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
